load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a word-wide data memory
// with a one-cycle read latency. Sub-word stores are read-modify-write.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and every req_* field is captured on that edge.

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        err_q;
  logic [15:0] st_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req_err;
  logic        accept;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [31:0] load_val;
  logic [31:0] st_mask;
  logic [31:0] st_data;
  logic [31:0] merged;

  assign req_ready  = rst && (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid && err_q;
  assign mem_we     = (state == S_WR);
  assign mem_addr   = {2'b00, addr_q[31:2]};
  assign mem_wdata  = wdata_q;
  assign dbg_state  = state;

  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: req_err = 1'b0;
      3'b001, 3'b101: req_err = req_addr[0];
      3'b010:         req_err = (req_addr[1:0] != 2'b00);
      default:        req_err = 1'b1;
    endcase
    if (req_we && req_funct3[2]) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_LIMIT) req_err = 1'b1;
  end

  // Lane extraction for loads: shift the selected byte/halfword down to bit 0.
  always_comb begin
    byte_sh  = mem_rdata >> {addr_q[1:0], 3'b000};
    half_sh  = mem_rdata >> {addr_q[1], 4'b0000};
    load_val = mem_rdata;
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {24'd0, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_val = {16'd0, half_sh[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // Sub-word store merge: replicate the data across lanes and keep only the target lanes.
  always_comb begin
    if (funct3_q[1:0] == 2'b00) begin
      st_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      st_data = {4{st_q[7:0]}};
    end else begin
      st_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      st_data = {2{st_q}};
    end
    merged = (mem_rdata & ~st_mask) | (st_data & st_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      st_q     <= 16'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            err_q    <= req_err;
            st_q     <= req_wdata[15:0];
            wdata_q  <= req_wdata;
            rdata_q  <= 32'd0;
            if (req_err)                             state <= S_RESP;
            else if (req_we && req_funct3 == 3'b010) state <= S_WR;
            else                                     state <= S_RD;
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          if (we_q) begin
            wdata_q <= merged;
            state   <= S_WR;
          end else begin
            rdata_q <= load_val;
            state   <= S_RESP;
          end
        end
        S_WR:    state <= S_RESP;
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
